move_input_conditioner: RTL

- Upstream input stage for the tic-tac-toe game FSM: conditions raw board inputs before the game FSM consumes them.
- Synchronises and debounces the active-low select and reset push-buttons, and samples the 9 move switches.
- Emits exactly one validated move (square index 0..8) per select press, with a valid/ready handshake, plus a single-cycle reset request.
- Replaces the game FSM's millisecond button polling and its level-sensitive treatment of held buttons.

---
 rtl/tictactoe_pkg.sv | 37 +++
 rtl/key_debounce.sv | 59 +++++
 rtl/move_input_conditioner.sv | 134 +++++++++++++
 3 files changed

// File: rtl/tictactoe_pkg.sv
// Shared tic-tac-toe types: square encoding, move index type and the
// input-conditioner FSM states, plus one-hot helpers for the move switches.
package tictactoe_pkg;

   localparam int unsigned NUM_SQUARES = 9;

   localparam logic [1:0] SQ_EMPTY = 2'b00;
   localparam logic [1:0] SQ_P1    = 2'b01;
   localparam logic [1:0] SQ_P2    = 2'b10;

   typedef logic [3:0] move_idx_t;

   typedef enum logic [1:0] {
      StIdle,
      StHold,
      StWaitRel
   } mic_state_e;

   function automatic logic is_onehot(input logic [NUM_SQUARES-1:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < NUM_SQUARES; i++) begin
         n = n + {3'b000, v[i]};
      end
      return (n == 4'd1);
   endfunction

   function automatic move_idx_t onehot_to_idx(input logic [NUM_SQUARES-1:0] v);
      move_idx_t idx;
      idx = '0;
      for (int i = 0; i < NUM_SQUARES; i++) begin
         if (v[i]) idx = move_idx_t'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Active-low push-button conditioner: 2-FF synchroniser, tick-gated debounce
// counter, stable level and a registered one-cycle press (1->0) pulse.
module key_debounce #(
   parameter int unsigned DEBOUNCE_TICKS = 10
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic tick_i,
   input  logic key_n_i,
   output logic stable_o,
   output logic press_o
);

   localparam int unsigned CntW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;

   logic            sync1_q, sync2_q;
   logic            stable_q, stable_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            press_q, press_d;

   always_comb begin
      stable_d = stable_q;
      cnt_d    = cnt_q;
      if (tick_i) begin
         if (sync2_q != stable_q) begin
            if (cnt_q == CntW'(DEBOUNCE_TICKS - 1)) begin
               stable_d = sync2_q;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end else begin
            // Any agreeing sample restarts the count, so glitches never accumulate.
            cnt_d = '0;
         end
      end
      press_d = stable_q & ~stable_d;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q  <= 1'b1;
         sync2_q  <= 1'b1;
         stable_q <= 1'b1;
         cnt_q    <= '0;
         press_q  <= 1'b0;
      end else begin
         sync1_q  <= key_n_i;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         press_q  <= press_d;
      end
   end

   assign stable_o = stable_q;
   assign press_o  = press_q;

endmodule

// File: rtl/move_input_conditioner.sv
// Board input stage for the game FSM: debounced select/reset keys, synchronised
// move switches, one validated move per select press and a one-cycle reset request.
module move_input_conditioner
   import tictactoe_pkg::*;
#(
   parameter int unsigned CLK_HZ         = 50000000,
   parameter int unsigned TICK_HZ        = 1000,
   parameter int unsigned DEBOUNCE_TICKS = 10
) (
   input  logic                   MAX10_CLK1_50,
   input  logic                   rst,
   input  logic                   key_select_n,
   input  logic                   key_reset_n,
   input  logic [NUM_SQUARES-1:0] sw_move,
   output logic                   move_valid,
   output logic [3:0]             move_idx,
   input  logic                   move_ready,
   output logic                   bad_move,
   output logic                   rst_req
);

   localparam int unsigned TickPeriod = CLK_HZ / TICK_HZ;
   localparam int unsigned TickW      = (TickPeriod > 1) ? $clog2(TickPeriod) : 1;

   logic [TickW-1:0]       tick_cnt_q, tick_cnt_d;
   logic                   tick;
   logic [NUM_SQUARES-1:0] sw_sync1_q, sw_sync2_q;
   logic                   sel_stable, sel_press, rst_stable, rst_press;

   mic_state_e state_q, state_d;
   logic       move_valid_q, move_valid_d;
   move_idx_t  move_idx_q, move_idx_d;
   logic       bad_move_q, bad_move_d;
   logic       rst_req_q, rst_req_d;

   assign tick = (tick_cnt_q == TickW'(TickPeriod - 1));

   always_comb begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
   end

   key_debounce #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
   ) u_sel_db (
      .clk_i   (MAX10_CLK1_50),
      .rst_i   (rst),
      .tick_i  (tick),
      .key_n_i (key_select_n),
      .stable_o(sel_stable),
      .press_o (sel_press)
   );

   key_debounce #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
   ) u_rst_db (
      .clk_i   (MAX10_CLK1_50),
      .rst_i   (rst),
      .tick_i  (tick),
      .key_n_i (key_reset_n),
      .stable_o(rst_stable),
      .press_o (rst_press)
   );

   always_comb begin
      state_d      = state_q;
      move_valid_d = move_valid_q;
      move_idx_d   = move_idx_q;
      bad_move_d   = 1'b0;
      rst_req_d    = 1'b0;
      if (rst_press) begin
         // Reset key overrides everything, including a simultaneous select press.
         rst_req_d    = 1'b1;
         move_valid_d = 1'b0;
         state_d      = sel_stable ? StIdle : StWaitRel;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (sel_press) begin
                  if (is_onehot(sw_sync2_q)) begin
                     move_idx_d   = onehot_to_idx(sw_sync2_q);
                     move_valid_d = 1'b1;
                     state_d      = StHold;
                  end else begin
                     bad_move_d = 1'b1;
                     state_d    = StWaitRel;
                  end
               end
            end
            StHold: begin
               if (move_ready) begin
                  move_valid_d = 1'b0;
                  state_d      = sel_stable ? StIdle : StWaitRel;
               end
            end
            StWaitRel: begin
               if (sel_stable) state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge MAX10_CLK1_50) begin
      if (rst) begin
         tick_cnt_q   <= '0;
         sw_sync1_q   <= '0;
         sw_sync2_q   <= '0;
         state_q      <= StIdle;
         move_valid_q <= 1'b0;
         move_idx_q   <= '0;
         bad_move_q   <= 1'b0;
         rst_req_q    <= 1'b0;
      end else begin
         tick_cnt_q   <= tick_cnt_d;
         sw_sync1_q   <= sw_move;
         sw_sync2_q   <= sw_sync1_q;
         state_q      <= state_d;
         move_valid_q <= move_valid_d;
         move_idx_q   <= move_idx_d;
         bad_move_q   <= bad_move_d;
         rst_req_q    <= rst_req_d;
      end
   end

   assign move_valid = move_valid_q;
   assign move_idx   = move_idx_q;
   assign bad_move   = bad_move_q;
   assign rst_req    = rst_req_q;

   // Reset-key level only matters through its press pulse.
   logic unused_rst_stable;
   assign unused_rst_stable = rst_stable;

endmodule
